// File: rtl/bin2bcd_pkg.sv
// Shared definitions for the iterative double-dabble binary-to-BCD converter.
//   state_e      : controller states IDLE / OP / DONE (2-bit encoding)
//   BCD_DIGIT_W  : width of one packed BCD digit
//   dabble_adj   : add-3 correction applied to a digit before each shift
package bin2bcd_pkg;

  localparam int BCD_DIGIT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OP   = 2'd1,
    DONE = 2'd2
  } state_e;

  // Digits 5..9 become 8..12 so the following left shift carries correctly
  // into the next decimal place. Inputs above 9 never occur in operation.
  function automatic logic [BCD_DIGIT_W-1:0] dabble_adj(input logic [BCD_DIGIT_W-1:0] d);
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// One decimal place of the double-dabble shift chain.
// Ports:
//   digit_i : current 4-bit digit register value
//   carry_i : bit shifted in from the next lower place (or the binary MSB)
//   digit_o : digit value after add-3 correction and one left shift
//   carry_o : corrected bit 3, shifted out toward the next higher place
module bcd_digit_cell
  import bin2bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] digit_i,
  input  logic                   carry_i,
  output logic [BCD_DIGIT_W-1:0] digit_o,
  output logic                   carry_o
);

  logic [BCD_DIGIT_W-1:0] adj;

  assign adj     = dabble_adj(digit_i);
  assign digit_o = {adj[BCD_DIGIT_W-2:0], carry_i};
  assign carry_o = adj[BCD_DIGIT_W-1];

endmodule

// File: rtl/bin2bcd_param.sv
// Parametrised iterative binary-to-BCD converter (double dabble, one shift
// per clock) with start/ready/done_tick handshake.
// Parameters:
//   BIN_W  : binary operand width, 1..32
//   DIGITS : number of BCD output digits, 1..10
//   CNT_W  : shift-counter width, derived; leave at its default
// Ports:
//   clk       : system clock, rising edge
//   reset     : asynchronous active-high reset
//   start     : conversion request, honoured only while ready=1
//   bin       : unsigned operand, captured on the accepted start
//   ready     : high while idle
//   done_tick : one-cycle pulse when bcd/overflow/blank are valid
//   bcd       : packed digits, digit i = bcd[4i+3:4i]
//   overflow  : operand exceeded 10^DIGITS-1 (bcd then holds operand mod 10^DIGITS)
//   blank     : leading-zero mask
// Build option:
//   BIN2BCD_BLANK_EN : when defined, blank[i] (i>=1) flags digit i and all
//                      higher digits as zero; otherwise blank is tied to 0.
module bin2bcd_param
  import bin2bcd_pkg::*;
#(
  parameter int BIN_W  = 14,
  parameter int DIGITS = 4,
  parameter int CNT_W  = $clog2(BIN_W + 1)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [BIN_W-1:0]              bin,
  output logic                          ready,
  output logic                          done_tick,
  output logic [BCD_DIGIT_W*DIGITS-1:0] bcd,
  output logic                          overflow,
  output logic [DIGITS-1:0]             blank
);

  generate
    if (BIN_W < 1 || BIN_W > 32 || DIGITS < 1 || DIGITS > 10 ||
        CNT_W != $clog2(BIN_W + 1)) begin : g_bad_param
      $error("bin2bcd_param: illegal parameters BIN_W=%0d DIGITS=%0d CNT_W=%0d",
             BIN_W, DIGITS, CNT_W);
    end
  endgenerate

  state_e                          state_q;
  logic [BIN_W-1:0]                sreg_q;
  logic [BCD_DIGIT_W*DIGITS-1:0]   dig_q;
  logic [BCD_DIGIT_W*DIGITS-1:0]   dig_d;
  logic [CNT_W-1:0]                cnt_q;
  logic                            ovf_acc_q;
  logic [BCD_DIGIT_W*DIGITS-1:0]   bcd_q;
  logic                            ovf_q;
  logic [DIGITS:0]                 carry;
  logic                            last_shift;
  logic                            ovf_d;

  // The binary MSB feeds digit 0; whatever leaves the top digit is lost
  // precision and therefore marks overflow.
  assign carry[0] = sreg_q[BIN_W-1];

  generate
    for (genvar i = 0; i < DIGITS; i++) begin : g_cell
      bcd_digit_cell u_cell (
        .digit_i (dig_q[BCD_DIGIT_W*i +: BCD_DIGIT_W]),
        .carry_i (carry[i]),
        .digit_o (dig_d[BCD_DIGIT_W*i +: BCD_DIGIT_W]),
        .carry_o (carry[i+1])
      );
    end
  endgenerate

  assign last_shift = (cnt_q == CNT_W'(1));
  assign ovf_d      = ovf_acc_q | carry[DIGITS];

  // Working digits are kept apart from bcd_q so the output reads 0 during OP
  // and holds the finished result from DONE until the next accepted start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      sreg_q    <= '0;
      dig_q     <= '0;
      cnt_q     <= '0;
      ovf_acc_q <= 1'b0;
      bcd_q     <= '0;
      ovf_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            sreg_q    <= bin;
            dig_q     <= '0;
            cnt_q     <= CNT_W'(BIN_W);
            ovf_acc_q <= 1'b0;
            bcd_q     <= '0;
            ovf_q     <= 1'b0;
            state_q   <= OP;
          end
        end
        OP: begin
          sreg_q    <= sreg_q << 1;
          dig_q     <= dig_d;
          ovf_acc_q <= ovf_d;
          cnt_q     <= cnt_q - CNT_W'(1);
          if (last_shift) begin
            bcd_q   <= dig_d;
            ovf_q   <= ovf_d;
            state_q <= DONE;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign ready     = (state_q == IDLE);
  assign done_tick = (state_q == DONE);
  assign bcd       = bcd_q;
  assign overflow  = ovf_q;

`ifdef BIN2BCD_BLANK_EN
  logic [DIGITS-1:0] blank_q;
  logic [DIGITS-1:0] blank_d;
  logic              zero_above;

  // Scan from the most significant digit down; a digit is blanked only while
  // it and everything above it is zero. Digit 0 always stays visible.
  always_comb begin
    blank_d    = '0;
    zero_above = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_above = zero_above && (dig_d[BCD_DIGIT_W*i +: BCD_DIGIT_W] == 4'd0);
      blank_d[i] = zero_above;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blank_q <= '0;
    end else if (state_q == IDLE && start) begin
      blank_q <= '0;
    end else if (state_q == OP && last_shift) begin
      blank_q <= blank_d;
    end
  end

  assign blank = blank_q;
`else
  assign blank = '0;
`endif

endmodule

// File: doc/bin2bcd_param.md
Name: bin2bcd_param

Overview:
Parametrised iterative double-dabble binary-to-BCD converter. It is the successor to the fixed 14-bit/4-digit converter and feeds the seven-segment display path, including the reaction-timer readout. It adds generic width and digit count, a sticky overflow flag, an input-hold register, and optional leading-zero blanking. It uses a start/ready/done_tick handshake with one shift per clock.

Parameters:
BIN_W, 14, binary input width; legal range 1..32.
DIGITS, 4, number of BCD output digits; legal range 1..10.
CNT_W, $clog2(BIN_W+1), derived shift-counter width; not to be overridden.

Ports:
clk  in  1  system clock; all state changes on the rising edge.
reset  in  1  asynchronous, active-high reset.
start  in  1  conversion request; sampled only while ready=1.
bin  in  BIN_W  unsigned binary operand; captured on the accepted start.
ready  out  1  high in IDLE.
done_tick  out  1  one-cycle pulse; result valid.
bcd  out  4*DIGITS  packed digits; digit i = bcd[4i+3:4i], digit 0 least significant.
overflow  out  1  operand exceeded 10^DIGITS-1; valid with done_tick.
blank  out  DIGITS  leading-zero mask; see Optional Feature.

Behaviour:
- Reset (asynchronous, any state, including mid-conversion):
  - state=IDLE; bcd=0, overflow=0, blank=0, shift register=0, counter=0.
  - ready=1 and done_tick=0 combinationally after reset.
- Outputs ready and done_tick are Moore outputs of the state; bcd, overflow and blank are registered.
- States:
  - IDLE: ready=1. When start=1 at edge E0:
    - capture bin into the shift register;
    - clear all digits and overflow;
    - counter=BIN_W;
    - go to OP.
  - OP: ready=0. One shift per edge:
    - each digit ≥5 gets +3 (4-bit wrap-free; max 12), then the whole {digits, shift register} chain shifts left by 1;
    - the binary MSB enters digit 0 bit 0;
    - the adjusted bit 3 of the top digit is shifted out and ORed into overflow (sticky);
    - counter decrements; on the edge where it reaches 0, go to DONE.
  - DONE: done_tick=1 for exactly one cycle; go to IDLE unconditionally.
- Latency:
  - Accepted start at E0 gives done_tick high between edges E_BIN_W and E_BIN_W+1.
  - ready is high again after E_BIN_W+1.
  - Back-to-back throughput is one conversion per BIN_W+2 cycles.
- start while ready=0: ignored, no queueing. start held high re-triggers on every IDLE cycle.
- bin may change freely after the accepted start edge without affecting the result.
- bcd, overflow and blank hold their values from DONE until the next accepted start, then read as 0 during OP.
- On overflow, bcd equals the operand mod 10^DIGITS (low digits are correct).
- The binary value 0 yields bcd=0 and overflow=0.
- Illegal parameters: elaboration-time error.

Optional Feature:
Macro: BIN2BCD_BLANK_EN.
- Defined:
  - blank is registered at the DONE transition.
  - blank[i]=1 iff digit i and all higher digits are 0, for i≥1.
  - blank[0] is always 0.
  - blank is cleared on start and on reset.
- Undefined: blank is tied to all zeros; no blanking logic is synthesised.

Decomposition:
- Shared package bin2bcd_pkg:
  - state enum IDLE/OP/DONE (2-bit);
  - constant BCD_DIGIT_W=4;
  - function dabble_adj(4-bit) returning the digit +3 when ≥5.
- One sub-module, bcd_digit_cell:
  - inputs: 4-bit digit register and carry-in bit;
  - outputs: next digit and carry-out;
  - instantiated DIGITS times in a generate chain.
- The top module holds the FSM, counter, shift register, overflow and blank logic.

Test Plan:
- Default params, bin=9999, start pulse → done_tick exactly 14 edges after the start edge; bcd=0x9999, overflow=0, ready low for 15 cycles.
- Default params, bin=16383 → bcd=0x6383, overflow=1.
- BIN_W=8, DIGITS=3, bin=255 then bin=0 back-to-back with start held high → results 0x255 then 0x000, each done_tick one cycle wide, 10 cycles apart.
- Assert reset at the 5th OP cycle of a conversion of 1234 → immediately ready=1, bcd=0, no done_tick; a following start with bin=42 yields 0x0042.
- start pulses during OP and DONE, plus a bin change after acceptance → ignored; result matches the captured operand.
- With BIN2BCD_BLANK_EN: bin=42 → blank=4'b1100; bin=0 → blank=4'b1110. Without the macro: blank=0 for both.
